axi_lite_scratchpad: RTL and testbench
======================================

# axi_lite_scratchpad

AXI4-Lite responder (slave) exposing a word-addressed, byte-strobed scratchpad RAM on the holy_core non-cachable path. It receives the single-beat transactions the data cache issues through `m_axi_lite` when an address falls in the CSR-defined non-cachable window. It terminates them with OKAY or SLVERR responses. Read and write channels are independent and can be in flight at the same time.

## Interface
- `BASE_ADDR`, default 32'h0000_3000: byte address of word 0.
- `DEPTH_WORDS`, default 256: number of 32-bit words; must be a power of two ≥ 2.
- `clk` in 1: clock.
- `rst_n` in 1: reset, synchronous, active-low.
- `s_axi_lite` (`axi_lite_if.slave` modport), carrying the signals below:
- `awaddr` in 32, `awvalid` in 1, `awready` out 1: write address channel.
- `wdata` in 32, `wstrb` in 4, `wvalid` in 1, `wready` out 1: write data channel.
- `bresp` out 2, `bvalid` out 1, `bready` in 1: write response channel.
- `araddr` in 32, `arvalid` in 1, `arready` out 1: read address channel.
- `rdata` out 32, `rresp` out 2, `rvalid` out 1, `rready` in 1: read data channel.

## Operation
- Address decode: `offset = addr - BASE_ADDR` (32-bit, wraps). The access is in range iff `offset < DEPTH_WORDS*4`. Word index is `offset[log2(DEPTH_WORDS)+1:2]`. `addr[1:0]` is ignored.
- Write FSM states:
  - W_IDLE: `awready=1`, `wready=1`.
    - AW and W both valid: commit the write, go to W_RESP.
    - AW only: latch the address, go to W_WAIT_DATA.
    - W only: latch data and strobe, go to W_WAIT_ADDR.
  - W_WAIT_DATA: `wready=1`, `awready=0`. On `wvalid`, commit, go to W_RESP.
  - W_WAIT_ADDR: `awready=1`, `wready=0`. On `awvalid`, commit, go to W_RESP.
  - W_RESP: `bvalid=1`. On `bready`, go to W_IDLE.
- Commit rules:
  - In range: byte i written iff `wstrb[i]`; `bresp`=OKAY (2'b00).
  - Out of range: RAM untouched; `bresp`=SLVERR (2'b10).
  - `wstrb`=0 in range: no bytes change; response is OKAY.
- Read FSM states:
  - R_IDLE: `arready=1`. On `arvalid`, latch the address, go to R_READ.
  - R_READ: RAM is sampled at the end of this cycle. Go to R_RESP.
  - R_RESP: `rvalid=1`. On `rready`, go to R_IDLE.
- Read data:
  - In range: `rdata` = RAM word, `rresp`=OKAY.
  - Out of range: `rdata`=32'h0, `rresp`=SLVERR.
- Ready signals are decoded from FSM state only and never depend on the corresponding valid (no combinational valid→ready path).
- `bresp`, `rdata` and `rresp` are registered and stay stable while their valid is high and not yet accepted.

## Timing
- Reset: while `rst_n=0`, all ready and valid outputs are 0, `bresp`=0, `rresp`=0, `rdata`=0. Both FSMs go to IDLE.
- RAM contents are not reset.
- Reset asserted mid-transaction drops all latched state; no response is issued for it.
- Write latency:
  - AW and W accepted together at edge N: RAM updated at edge N, `bvalid` high in cycle N+1.
  - AW and W accepted at different edges: same timing, measured from the later handshake.
- Read latency: AR accepted at edge N → R_READ in cycle N+1 → `rvalid` high in cycle N+2.
- Back-to-back throughput:
  - One write per 2 cycles when `bready` is held high.
  - One read per 3 cycles when `rready` is held high.
- Simultaneous write commit and read sample on the same edge to the same word: read-first. The read returns the old data; the new data is visible to the next read.
- `bready`/`rready` may be held high before valid rises. The response completes in its first valid cycle.
- A held-off response (ready low) blocks only its own channel; the other channel keeps operating.

## Structure
- Additions to `holy_core_pkg`:
  - `axi_lite_wstate_t` (W_IDLE, W_WAIT_DATA, W_WAIT_ADDR, W_RESP).
  - `axi_lite_rstate_t` (R_IDLE, R_READ, R_RESP).
  - Constants `AXI_RESP_OKAY`=2'b00, `AXI_RESP_SLVERR`=2'b10.
- One sub-module, `lite_ram_1r1w`: `DEPTH_WORDS`×32 array with
  - a write port: 4-bit byte enable, write on the clock edge;
  - a registered read port with read-first ordering.
- The top level holds the two FSMs, the address/data latches and the decode logic.

## Test plan
- Full write/read: AW+W together to 32'h3004 with data 32'hCAFEBABE, `wstrb`=4'hF → `bresp`=OKAY one cycle later. Read of 32'h3004 → `rdata`=32'hCAFEBABE, `rvalid` exactly 2 cycles after AR handshake.
- Byte strobes: preload 32'h11223344, write 32'hAABBCCDD with `wstrb`=4'b0101 → read returns 32'h11BB33DD.
- Split channels: W presented 3 cycles before AW, then reversed order → both commit correctly; `wready`/`awready` deassert while waiting for the other channel; one B response each.
- Out of range: write and read at 32'h3400 (DEPTH 256) → `bresp`=SLVERR, `rresp`=SLVERR, `rdata`=0; a read of word 0 confirms no alias write. Also access 32'h2FFC → SLVERR via wrap.
- Back-pressure and concurrency: hold `bready`=0 for 5 cycles while a read completes → read is unaffected, `bresp` stays stable. Same-edge write/read to one word → old value returned, new value on the following read.
- Reset mid-op: assert `rst_n=0` while in W_WAIT_DATA and while in R_RESP → all valids/readies drop to 0; after release, the FSMs accept new transactions with no stale response.

Source files
------------

// File: rtl/holy_core_pkg.sv
// Shared holy_core types and constants used by the AXI4-Lite scratchpad responder.
package holy_core_pkg;

    typedef enum logic [1:0] {
        W_IDLE,
        W_WAIT_DATA,
        W_WAIT_ADDR,
        W_RESP
    } axi_lite_wstate_t;

    typedef enum logic [1:0] {
        R_IDLE,
        R_READ,
        R_RESP
    } axi_lite_rstate_t;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

endpackage

// File: rtl/axi_lite_if.sv
// AXI4-Lite bundle used on the non-cachable data path.
interface axi_lite_if;

    logic [31:0] awaddr;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;
    logic [31:0] araddr;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;

    modport slave (
        input  awaddr, awvalid, output awready,
        input  wdata, wstrb, wvalid, output wready,
        output bresp, bvalid, input bready,
        input  araddr, arvalid, output arready,
        output rdata, rresp, rvalid, input rready
    );

    modport master (
        output awaddr, awvalid, input awready,
        output wdata, wstrb, wvalid, input wready,
        input  bresp, bvalid, output bready,
        output araddr, arvalid, input arready,
        input  rdata, rresp, rvalid, output rready
    );

endinterface

// File: rtl/lite_ram_1r1w.sv
// Byte-enabled 32-bit RAM with one write port and one registered, read-first read port.
module lite_ram_1r1w #(
    parameter int DEPTH_WORDS = 256,
    parameter int IDX_W       = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             we,
    input  logic [3:0]       wbe,
    input  logic [IDX_W-1:0] waddr,
    input  logic [31:0]      wdata,
    input  logic             re,
    input  logic [IDX_W-1:0] raddr,
    output logic [31:0]      rdata
);

    logic [31:0] mem [DEPTH_WORDS];
    logic [31:0] rdata_d, rdata_q;

    // Array contents are deliberately left unreset.
    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < 4; i++) begin
                if (wbe[i]) mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
    end

    // Read sees the pre-edge contents, so a same-edge write is not observed.
    always_comb begin
        rdata_d = rdata_q;
        if (re) rdata_d = mem[raddr];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) rdata_q <= '0;
        else        rdata_q <= rdata_d;
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/axi_lite_scratchpad.sv
// AXI4-Lite responder exposing a byte-strobed scratchpad; independent read and write FSMs.
module axi_lite_scratchpad
    import holy_core_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = 32'h0000_3000,
    parameter int          DEPTH_WORDS = 256
) (
    input  logic       clk,
    input  logic       rst_n,
    axi_lite_if.slave  s_axi_lite
);

    localparam int          IDX_W = $clog2(DEPTH_WORDS);
    localparam logic [31:0] SPAN  = 32'(DEPTH_WORDS) << 2;

    function automatic logic in_range(input logic [31:0] addr);
        logic [31:0] off;
        off = addr - BASE_ADDR;
        return off < SPAN;
    endfunction

    function automatic logic [IDX_W-1:0] word_idx(input logic [31:0] addr);
        logic [31:0] off;
        off = addr - BASE_ADDR;
        return IDX_W'(off >> 2);
    endfunction

    axi_lite_wstate_t wstate_d, wstate_q;
    axi_lite_rstate_t rstate_d, rstate_q;
    logic [31:0] awaddr_d, awaddr_q, wdata_d, wdata_q, araddr_d, araddr_q;
    logic [3:0]  wstrb_d, wstrb_q;
    logic [1:0]  bresp_d, bresp_q, rresp_d, rresp_q;

    logic        commit, commit_ok, ram_we, ram_re;
    logic [31:0] c_addr, c_data;
    logic [3:0]  c_strb;
    logic [31:0] ram_rdata;

    // Whichever handshake completes last supplies its live bus value to the commit.
    always_comb begin
        wstate_d = wstate_q;
        awaddr_d = awaddr_q;
        wdata_d  = wdata_q;
        wstrb_d  = wstrb_q;
        bresp_d  = bresp_q;
        commit   = 1'b0;
        c_addr   = awaddr_q;
        c_data   = wdata_q;
        c_strb   = wstrb_q;
        case (wstate_q)
            W_IDLE: begin
                if (s_axi_lite.awvalid && s_axi_lite.wvalid) begin
                    commit   = 1'b1;
                    c_addr   = s_axi_lite.awaddr;
                    c_data   = s_axi_lite.wdata;
                    c_strb   = s_axi_lite.wstrb;
                    wstate_d = W_RESP;
                end else if (s_axi_lite.awvalid) begin
                    awaddr_d = s_axi_lite.awaddr;
                    wstate_d = W_WAIT_DATA;
                end else if (s_axi_lite.wvalid) begin
                    wdata_d  = s_axi_lite.wdata;
                    wstrb_d  = s_axi_lite.wstrb;
                    wstate_d = W_WAIT_ADDR;
                end
            end
            W_WAIT_DATA: begin
                if (s_axi_lite.wvalid) begin
                    commit   = 1'b1;
                    c_data   = s_axi_lite.wdata;
                    c_strb   = s_axi_lite.wstrb;
                    wstate_d = W_RESP;
                end
            end
            W_WAIT_ADDR: begin
                if (s_axi_lite.awvalid) begin
                    commit   = 1'b1;
                    c_addr   = s_axi_lite.awaddr;
                    wstate_d = W_RESP;
                end
            end
            W_RESP: begin
                if (s_axi_lite.bready) wstate_d = W_IDLE;
            end
            default: wstate_d = W_IDLE;
        endcase
        commit_ok = in_range(c_addr);
        if (commit) bresp_d = commit_ok ? AXI_RESP_OKAY : AXI_RESP_SLVERR;
        ram_we = commit && commit_ok && rst_n;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wstate_q <= W_IDLE;
            awaddr_q <= '0;
            wdata_q  <= '0;
            wstrb_q  <= '0;
            bresp_q  <= AXI_RESP_OKAY;
        end else begin
            wstate_q <= wstate_d;
            awaddr_q <= awaddr_d;
            wdata_q  <= wdata_d;
            wstrb_q  <= wstrb_d;
            bresp_q  <= bresp_d;
        end
    end

    always_comb begin
        rstate_d = rstate_q;
        araddr_d = araddr_q;
        rresp_d  = rresp_q;
        case (rstate_q)
            R_IDLE: begin
                if (s_axi_lite.arvalid) begin
                    araddr_d = s_axi_lite.araddr;
                    rstate_d = R_READ;
                end
            end
            R_READ: begin
                rresp_d  = in_range(araddr_q) ? AXI_RESP_OKAY : AXI_RESP_SLVERR;
                rstate_d = R_RESP;
            end
            R_RESP: begin
                if (s_axi_lite.rready) rstate_d = R_IDLE;
            end
            default: rstate_d = R_IDLE;
        endcase
        ram_re = (rstate_q == R_READ) && rst_n;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rstate_q <= R_IDLE;
            araddr_q <= '0;
            rresp_q  <= AXI_RESP_OKAY;
        end else begin
            rstate_q <= rstate_d;
            araddr_q <= araddr_d;
            rresp_q  <= rresp_d;
        end
    end

    lite_ram_1r1w #(
        .DEPTH_WORDS(DEPTH_WORDS),
        .IDX_W      (IDX_W)
    ) u_ram (
        .clk  (clk),
        .rst_n(rst_n),
        .we   (ram_we),
        .wbe  (c_strb),
        .waddr(word_idx(c_addr)),
        .wdata(c_data),
        .re   (ram_re),
        .raddr(word_idx(araddr_q)),
        .rdata(ram_rdata)
    );

    // Readies/valids are masked during reset so nothing is offered before the first edge.
    assign s_axi_lite.awready = rst_n && (wstate_q == W_IDLE || wstate_q == W_WAIT_ADDR);
    assign s_axi_lite.wready  = rst_n && (wstate_q == W_IDLE || wstate_q == W_WAIT_DATA);
    assign s_axi_lite.bvalid  = rst_n && (wstate_q == W_RESP);
    assign s_axi_lite.bresp   = bresp_q;
    assign s_axi_lite.arready = rst_n && (rstate_q == R_IDLE);
    assign s_axi_lite.rvalid  = rst_n && (rstate_q == R_RESP);
    assign s_axi_lite.rresp   = rresp_q;
    assign s_axi_lite.rdata   = (rresp_q == AXI_RESP_OKAY) ? ram_rdata : 32'h0;

endmodule

// File: tb/tb_axi_lite_scratchpad.sv
// Directed self-checking bench for axi_lite_scratchpad with hand-computed expectations.
module tb_axi_lite_scratchpad;

    logic clk;
    logic rst_n;
    int   vectors = 0;
    int   errors  = 0;

    axi_lite_if bus ();

    axi_lite_scratchpad dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .s_axi_lite(bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // AW and W together, B accepted one cycle after the handshake.
    task automatic applyStimulus(input string tag, input logic [31:0] addr, input logic [31:0] data,
                                 input logic [3:0] strb, input logic [1:0] exp_resp);
        bus.awaddr = addr; bus.wdata = data; bus.wstrb = strb;
        bus.awvalid = 1'b1; bus.wvalid = 1'b1;
        checkOutput({tag, "_rdy"}, 32'({bus.awready, bus.wready}), 32'h3);
        tick();
        bus.awvalid = 1'b0; bus.wvalid = 1'b0;
        checkOutput({tag, "_bvalid"}, 32'(bus.bvalid), 32'h1);
        checkOutput({tag, "_bresp"}, 32'(bus.bresp), 32'(exp_resp));
        bus.bready = 1'b1;
        tick();
        bus.bready = 1'b0;
        checkOutput({tag, "_bdone"}, 32'(bus.bvalid), 32'h0);
    endtask

    task automatic readWord(input string tag, input logic [31:0] addr,
                            input logic [31:0] exp_data, input logic [1:0] exp_resp);
        bus.araddr = addr; bus.arvalid = 1'b1;
        checkOutput({tag, "_arready"}, 32'(bus.arready), 32'h1);
        tick();
        bus.arvalid = 1'b0;
        checkOutput({tag, "_rvalid_n1"}, 32'(bus.rvalid), 32'h0);
        tick();
        checkOutput({tag, "_rvalid_n2"}, 32'(bus.rvalid), 32'h1);
        checkOutput({tag, "_rdata"}, bus.rdata, exp_data);
        checkOutput({tag, "_rresp"}, 32'(bus.rresp), 32'(exp_resp));
        bus.rready = 1'b1;
        tick();
        bus.rready = 1'b0;
        checkOutput({tag, "_rdone"}, 32'(bus.rvalid), 32'h0);
    endtask

    // One channel handshakes first; the other follows three cycles later.
    task automatic splitWrite(input string tag, input logic addr_first,
                              input logic [31:0] addr, input logic [31:0] data);
        bus.awaddr = addr; bus.wdata = data; bus.wstrb = 4'hF;
        if (addr_first) bus.awvalid = 1'b1;
        else            bus.wvalid  = 1'b1;
        tick();
        bus.awvalid = 1'b0; bus.wvalid = 1'b0;
        checkOutput({tag, "_wait_rdy"}, 32'({bus.awready, bus.wready}),
                    addr_first ? 32'h1 : 32'h2);
        checkOutput({tag, "_wait_bvalid"}, 32'(bus.bvalid), 32'h0);
        tick();
        tick();
        if (addr_first) bus.wvalid  = 1'b1;
        else            bus.awvalid = 1'b1;
        tick();
        bus.awvalid = 1'b0; bus.wvalid = 1'b0;
        checkOutput({tag, "_bvalid"}, 32'(bus.bvalid), 32'h1);
        checkOutput({tag, "_bresp"}, 32'(bus.bresp), 32'h0);
        bus.bready = 1'b1;
        tick();
        bus.bready = 1'b0;
        checkOutput({tag, "_bdone"}, 32'(bus.bvalid), 32'h0);
    endtask

    initial begin
        int bcount;
        rst_n = 1'b0;
        bus.awaddr = '0; bus.awvalid = 1'b0;
        bus.wdata = '0; bus.wstrb = '0; bus.wvalid = 1'b0;
        bus.bready = 1'b0;
        bus.araddr = '0; bus.arvalid = 1'b0;
        bus.rready = 1'b0;
        tick();
        tick();
        checkOutput("rst_readies", 32'({bus.awready, bus.wready, bus.arready}), 32'h0);
        checkOutput("rst_valids", 32'({bus.bvalid, bus.rvalid}), 32'h0);
        checkOutput("rst_resps", 32'({bus.bresp, bus.rresp}), 32'h0);
        checkOutput("rst_rdata", bus.rdata, 32'h0);
        rst_n = 1'b1;
        tick();
        checkOutput("post_rst_readies", 32'({bus.awready, bus.wready, bus.arready}), 32'h7);

        applyStimulus("full_wr", 32'h3004, 32'hCAFEBABE, 4'hF, 2'b00);
        readWord("full_rd", 32'h3004, 32'hCAFEBABE, 2'b00);

        applyStimulus("strb_pre", 32'h3008, 32'h11223344, 4'hF, 2'b00);
        applyStimulus("strb_wr", 32'h3008, 32'hAABBCCDD, 4'b0101, 2'b00);
        readWord("strb_rd", 32'h3008, 32'h11BB33DD, 2'b00);
        applyStimulus("strb0_wr", 32'h3008, 32'hFFFFFFFF, 4'h0, 2'b00);
        readWord("strb0_rd", 32'h3008, 32'h11BB33DD, 2'b00);

        splitWrite("split_w1st", 1'b0, 32'h300C, 32'h12345678);
        readWord("split_w1st_rd", 32'h300C, 32'h12345678, 2'b00);
        splitWrite("split_aw1st", 1'b1, 32'h3010, 32'h9ABCDEF0);
        readWord("split_aw1st_rd", 32'h3010, 32'h9ABCDEF0, 2'b00);

        applyStimulus("w0_pre", 32'h3000, 32'h0BADF00D, 4'hF, 2'b00);
        applyStimulus("w255_pre", 32'h33FC, 32'h600DCAFE, 4'hF, 2'b00);
        applyStimulus("oor_wr", 32'h3400, 32'hDEADBEEF, 4'hF, 2'b10);
        readWord("oor_rd", 32'h3400, 32'h0, 2'b10);
        readWord("noalias_w0", 32'h3000, 32'h0BADF00D, 2'b00);
        applyStimulus("wrap_wr", 32'h2FFC, 32'h55555555, 4'hF, 2'b10);
        readWord("wrap_rd", 32'h2FFC, 32'h0, 2'b10);
        readWord("noalias_w255", 32'h33FC, 32'h600DCAFE, 2'b00);

        // Write response held off for five cycles while a read runs to completion.
        bus.awaddr = 32'h3400; bus.wdata = 32'h1; bus.wstrb = 4'hF;
        bus.awvalid = 1'b1; bus.wvalid = 1'b1;
        tick();
        bus.awvalid = 1'b0; bus.wvalid = 1'b0;
        bus.araddr = 32'h3004; bus.arvalid = 1'b1;
        checkOutput("bp_c0_b", 32'({bus.bvalid, bus.bresp}), 32'h6);
        checkOutput("bp_c0_awready", 32'(bus.awready), 32'h0);
        checkOutput("bp_c0_arready", 32'(bus.arready), 32'h1);
        tick();
        bus.arvalid = 1'b0;
        checkOutput("bp_c1_b", 32'({bus.bvalid, bus.bresp}), 32'h6);
        tick();
        checkOutput("bp_c2_rvalid", 32'(bus.rvalid), 32'h1);
        checkOutput("bp_c2_rdata", bus.rdata, 32'hCAFEBABE);
        checkOutput("bp_c2_b", 32'({bus.bvalid, bus.bresp}), 32'h6);
        bus.rready = 1'b1;
        tick();
        bus.rready = 1'b0;
        checkOutput("bp_c3_rvalid", 32'(bus.rvalid), 32'h0);
        checkOutput("bp_c3_b", 32'({bus.bvalid, bus.bresp}), 32'h6);
        tick();
        checkOutput("bp_c4_b", 32'({bus.bvalid, bus.bresp}), 32'h6);
        bus.bready = 1'b1;
        tick();
        bus.bready = 1'b0;
        checkOutput("bp_bdone", 32'(bus.bvalid), 32'h0);

        // Write commits on the very edge that ends R_READ for the same word.
        applyStimulus("rf_pre", 32'h3018, 32'h00000001, 4'hF, 2'b00);
        bus.araddr = 32'h3018; bus.arvalid = 1'b1;
        tick();
        bus.arvalid = 1'b0;
        bus.awaddr = 32'h3018; bus.wdata = 32'h00000002; bus.wstrb = 4'hF;
        bus.awvalid = 1'b1; bus.wvalid = 1'b1;
        tick();
        bus.awvalid = 1'b0; bus.wvalid = 1'b0;
        checkOutput("rf_rvalid", 32'(bus.rvalid), 32'h1);
        checkOutput("rf_old_data", bus.rdata, 32'h00000001);
        checkOutput("rf_bvalid", 32'(bus.bvalid), 32'h1);
        bus.rready = 1'b1; bus.bready = 1'b1;
        tick();
        bus.rready = 1'b0; bus.bready = 1'b0;
        readWord("rf_new_data", 32'h3018, 32'h00000002, 2'b00);

        // Back-to-back writes with bready held: one response every second cycle.
        bus.awaddr = 32'h3020; bus.wdata = 32'h5A5A5A5A; bus.wstrb = 4'hF;
        bus.awvalid = 1'b1; bus.wvalid = 1'b1; bus.bready = 1'b1;
        bcount = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (bus.bvalid) bcount++;
        end
        bus.awvalid = 1'b0; bus.wvalid = 1'b0; bus.bready = 1'b0;
        checkOutput("b2b_count", 32'(bcount), 32'h3);
        readWord("b2b_rd", 32'h3020, 32'h5A5A5A5A, 2'b00);

        // Reset lands with the write in W_WAIT_DATA and the read in R_RESP.
        bus.awaddr = 32'h301C; bus.awvalid = 1'b1;
        bus.araddr = 32'h3004; bus.arvalid = 1'b1;
        tick();
        bus.awvalid = 1'b0; bus.arvalid = 1'b0;
        checkOutput("mid_waitdata_rdy", 32'({bus.awready, bus.wready}), 32'h1);
        tick();
        checkOutput("mid_rresp_rvalid", 32'(bus.rvalid), 32'h1);
        rst_n = 1'b0;
        tick();
        checkOutput("mid_rst_readies", 32'({bus.awready, bus.wready, bus.arready}), 32'h0);
        checkOutput("mid_rst_valids", 32'({bus.bvalid, bus.rvalid}), 32'h0);
        checkOutput("mid_rst_rdata", bus.rdata, 32'h0);
        rst_n = 1'b1;
        tick();
        checkOutput("mid_rel_readies", 32'({bus.awready, bus.wready, bus.arready}), 32'h7);
        checkOutput("mid_rel_valids", 32'({bus.bvalid, bus.rvalid}), 32'h0);
        bus.wdata = 32'h77777777; bus.wstrb = 4'hF; bus.wvalid = 1'b1;
        tick();
        bus.wvalid = 1'b0;
        checkOutput("mid_no_stale_b", 32'(bus.bvalid), 32'h0);
        checkOutput("mid_waitaddr_rdy", 32'({bus.awready, bus.wready}), 32'h2);
        bus.awaddr = 32'h301C; bus.awvalid = 1'b1;
        tick();
        bus.awvalid = 1'b0;
        checkOutput("mid_new_bvalid", 32'(bus.bvalid), 32'h1);
        bus.bready = 1'b1;
        tick();
        bus.bready = 1'b0;
        checkOutput("mid_new_bdone", 32'(bus.bvalid), 32'h0);
        readWord("mid_new_rd", 32'h301C, 32'h77777777, 2'b00);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
